// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external combinational ALU, with one result register.
// Ports: cmd_* upstream handshake, alu_* head entry to ALU, res_* result handshake, count occupancy.
`timescale 1ns/1ps
module alu_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [1:0]               cmd_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [1:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          issue;
  logic          not_empty;

  assign not_empty = (count != '0);
  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // result register is free, or is being drained this cycle
  assign issue     = not_empty && (!res_valid || res_ready);

  always_comb begin
    head = '0;
    if (not_empty) head = mem[rd_ptr];
  end

  assign alu_a  = head.a;
  assign alu_b  = head.b;
  assign alu_op = head.op;

  // storage is not reset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, b: cmd_b, a: cmd_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_err   <= (alu_op != 2'b01) && (alu_op != 2'b10);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: vector table, corner sequences, random vs scoreboard.
// Drives an ideal ALU model on alu_result.
`timescale 1ns/1ps
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_a;
  logic [WIDTH-1:0]  cmd_b;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [1:0]        alu_op;
  logic [WIDTH-1:0]  alu_result;
  logic              res_valid;
  logic              res_ready;
  logic [WIDTH-1:0]  res_data;
  logic              res_err;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [16:0] exp_q[$];

  alu_cmd_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(
    input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    if (op == 2'b01) return {1'b0, 16'(a + b)};
    if (op == 2'b10) return {1'b0, p[15:0]};
    return {1'b1, 16'h0000};
  endfunction

  // ideal ALU: add, truncating mul, zero for illegal codes
  always_comb begin
    logic [16:0] r;
    r = model(alu_a, alu_b, alu_op);
    alu_result = r[15:0];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    logic        pf, rf, hold;
    logic [15:0] pd;
    logic        pe;
    logic [16:0] e;
    pf   = cmd_valid && cmd_ready;
    rf   = res_valid && res_ready;
    hold = res_valid && !res_ready;
    pd   = res_data;
    pe   = res_err;
    if (pf) exp_q.push_back(model(cmd_a, cmd_b, cmd_op));
    @(posedge clk);
    #1;
    if (rf) begin
      n_out++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(pd), 32'(e[15:0]));
        chk("sb_err", 32'(pe), 32'(e[16]));
      end
    end
    if (hold) begin
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_data", 32'(res_data), 32'(pd));
      chk("stall_err", 32'(res_err), 32'(pe));
    end
    chk("count_max", 32'(count <= 3'(DEPTH)), 32'd1);
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !res_valid) break;
      tick();
    end
    chk("drain_q", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(res_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] d;
    logic        e;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vt[0] = '{16'd3,    16'd5,    2'b01, 16'h0008, 1'b0};
    vt[1] = '{16'h0100, 16'h0101, 2'b10, 16'h0100, 1'b0};
    vt[2] = '{16'd7,    16'd9,    2'b11, 16'h0000, 1'b1};
    vt[3] = '{16'd2,    16'd3,    2'b01, 16'h0005, 1'b0};
    vt[4] = '{16'hFFFF, 16'h0001, 2'b01, 16'h0000, 1'b0};
    vt[5] = '{16'hFFFF, 16'hFFFF, 2'b10, 16'h0001, 1'b0};
    vt[6] = '{16'd4,    16'd4,    2'b00, 16'h0000, 1'b1};
    vt[7] = '{16'h1234, 16'h0010, 2'b10, 16'h2340, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("empty_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);

    // vector table: single commands, latency and no bypass
    res_ready = 1'b1;
    foreach (vt[i]) begin
      cmd_a = vt[i].a; cmd_b = vt[i].b; cmd_op = vt[i].op;
      cmd_valid = 1'b1;
      chk("vec_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("vec_nobypass", 32'(res_valid), 32'd0);
      chk("vec_head_a", 32'(alu_a), 32'(vt[i].a));
      tick();
      chk("vec_valid", 32'(res_valid), 32'd1);
      chk("vec_data", 32'(res_data), 32'(vt[i].d));
      chk("vec_err", 32'(res_err), 32'(vt[i].e));
    end
    drain();

    // backpressure to full, then in-order drain
    res_ready = 1'b0;
    cmd_op = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      cmd_a = 16'(i); cmd_b = 16'(i); cmd_valid = 1'b1;
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_held", 32'(res_data), 32'd2);
    cmd_a = 16'd6; cmd_b = 16'd6;
    tick();
    chk("full_count2", 32'(count), 32'd4);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_order", 32'(res_data), 32'(4 + 2 * i));
      chk("bp_valid", 32'(res_valid), 32'd1);
    end
    drain();

    // streaming with pointer wrap
    base = n_out;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      cmd_op = 2'($urandom_range(1, 2));
      tick();
      chk("stream_cnt", 32'(count <= 3'd1), 32'd1);
      if (i > 0) chk("stream_nogap", 32'(res_valid), 32'd1);
    end
    drain();
    chk("stream_n", 32'(n_out - base), 32'd20);

    // reset mid-stream
    res_ready = 1'b0;
    cmd_op = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cmd_a = 16'(i + 1); cmd_b = 16'd1; cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    chk("mid_rst_alu", 32'(alu_a), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    base = n_out;
    res_ready = 1'b1;
    cmd_a = 16'd4; cmd_b = 16'd4; cmd_op = 2'b01; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_data", 32'(res_data), 32'd8);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_n", 32'(n_out - base), 32'd1);
    chk("post_rst_idle", 32'(res_valid), 32'd0);

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      cmd_op = 2'($urandom_range(0, 3));
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of command FIFO entries; legal values are powers of two, 2..16.
REQ-002 Parameter WIDTH, default 16, meaning operand and result width; it SHALL match the ALU data width.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port cmd_valid, input, 1 bit: the upstream command is valid.
REQ-006 Port cmd_ready, output, 1 bit: the queue can accept a command.
REQ-007 Port cmd_a, input, WIDTH bits: operand a.
REQ-008 Port cmd_b, input, WIDTH bits: operand b.
REQ-009 Port cmd_op, input, 2 bits: opcode; 01 = add, 10 = mul, 00 and 11 are illegal.
REQ-010 Port alu_a, output, WIDTH bits: head-entry operand a, driven to the ALU.
REQ-011 Port alu_b, output, WIDTH bits: head-entry operand b, driven to the ALU.
REQ-012 Port alu_op, output, 2 bits: head-entry opcode, driven to the ALU.
REQ-013 Port alu_result, input, WIDTH bits: the combinational ALU result for alu_a, alu_b and alu_op.
REQ-014 Port res_valid, output, 1 bit: the result register holds a valid result.
REQ-015 Port res_ready, input, 1 bit: downstream accepts the result.
REQ-016 Port res_data, output, WIDTH bits: the captured result.
REQ-017 Port res_err, output, 1 bit: the captured command had an illegal opcode.
REQ-018 Port count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-019 Push: a command SHALL be written at the write pointer on a clock edge where cmd_valid and cmd_ready are both 1.
REQ-020 cmd_ready SHALL equal (count != DEPTH); it is registered-state-derived only, with no combinational path from res_ready.
REQ-021 alu_a, alu_b and alu_op SHALL show the head entry whenever count != 0, and SHALL be all zeros when the FIFO is empty.
REQ-022 Issue condition: (count != 0) and (res_valid == 0 or res_ready == 1).
REQ-023 On an issue edge, the block SHALL do all of the following: pop the head; load res_data <= alu_result; load res_err <= (alu_op not 01 and not 10); set res_valid <= 1.
REQ-024 If res_valid and res_ready are both 1 and there is no issue, res_valid SHALL go to 0; res_data and res_err SHALL hold.
REQ-025 While res_valid = 1 and res_ready = 0, res_data, res_err and res_valid SHALL stay stable and no issue SHALL occur.
REQ-026 Latency: a command accepted on edge k with an empty FIFO and a free result register SHALL have res_valid = 1 after edge k+1. There is no bypass from the command input to the result.
REQ-027 Throughput: with cmd_valid = 1 and res_ready = 1 held continuously, the block SHALL sustain one result per cycle.
REQ-028 Simultaneous push and issue on the same edge: count SHALL be unchanged and both operations SHALL complete.
REQ-029 When full (count = DEPTH): cmd_ready = 0 even if an issue occurs on the same cycle. The issue SHALL free the slot for the next cycle.
REQ-030 When empty: no issue; res_valid SHALL follow REQ-024.
REQ-031 Read and write pointers are $clog2(DEPTH) bits and SHALL wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
REQ-032 Results SHALL leave the block in command acceptance order.
REQ-033 The block SHALL pass alu_result unmodified; arithmetic and truncation are defined by the ALU.

Reset
REQ-034 While rst_n = 0, regardless of clk: count = 0, both pointers = 0, res_valid = 0, res_data = 0, res_err = 0.
REQ-035 A reset asserted mid-operation SHALL discard all queued commands and any pending result. FIFO storage contents need not be cleared.
REQ-036 After rst_n deasserts, cmd_ready SHALL be 1 and the first push is allowed on the first following edge.

Verification
REQ-037 Single add: push a=3, b=5, op=01 with res_ready=1 -> after edge k+1, res_valid=1, res_data=0x0008, res_err=0.
REQ-038 Mul with truncation: push a=0x0100, b=0x0101, op=10 -> res_data=0x0100, res_err=0.
REQ-039 Illegal opcode: push a=7, b=9, op=11 -> res_data=0x0000, res_err=1; the next legal command then produces res_err=0.
REQ-040 Backpressure and full:
- Hold res_ready=0 and push 6 commands (1+1, 2+2, ... 6+6, op=01) -> 1 result held plus 4 queued, and cmd_ready=0 with count=4.
- Then raise res_ready=1 -> results drain in order: 2, 4, 6, 8, 10, one per cycle.
REQ-041 Streaming with wrap-around: 20 back-to-back commands, continuous valid/ready -> 20 in-order results with no gaps after the first; count never exceeds 1.
REQ-042 Reset mid-stream: assert rst_n=0 with count=3 and res_valid=1 -> immediately count=0, res_valid=0, res_data=0. After release, one push (4+4) -> res_data=0x0008 only.
